// File: rtl/dmem_resp.sv
// Single-port data-memory responder: registered reads (1-cycle latency),
// writes, a post-reset clear sweep, sticky error flags and saturating counters.
module dmem_resp #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] datin,
  output logic [DATA_W-1:0] memdat,
  output logic              ack,
  output logic              ready,
  output logic              rd_uninit,
  output logic              access_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  // Handshake: a request is cs=1 sampled at a rising edge while in SERVE;
  // ack pulses high on the following cycle for every accepted request.

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0]  written_q, written_d;
  logic [DATA_W-1:0] memdat_q, memdat_d;
  logic              ack_q, ack_d;
  logic              ready_q, ready_d;
  logic              rd_uninit_q, rd_uninit_d;
  logic              access_err_q, access_err_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    written_d    = written_q;
    memdat_d     = memdat_q;
    ack_d        = 1'b0;
    ready_d      = ready_q;
    rd_uninit_d  = rd_uninit_q;
    access_err_d = access_err_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = address;
    mem_wdata    = datin;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (cs) access_err_d = 1'b1;
        if (clr_ptr_q == PTR_LAST) begin
          state_d = ST_SERVE;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (cs && rw) begin
          memdat_d = mem[address];
          ack_d    = 1'b1;
          if (rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
          if (!written_q[address]) rd_uninit_d = 1'b1;
        end else if (cs) begin
          mem_we             = 1'b1;
          written_d[address] = 1'b1;
          ack_d              = 1'b1;
          if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // The array has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      written_q    <= '0;
      memdat_q     <= '0;
      ack_q        <= 1'b0;
      ready_q      <= 1'b0;
      rd_uninit_q  <= 1'b0;
      access_err_q <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      written_q    <= written_d;
      memdat_q     <= memdat_d;
      ack_q        <= ack_d;
      ready_q      <= ready_d;
      rd_uninit_q  <= rd_uninit_d;
      access_err_q <= access_err_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign memdat     = memdat_q;
  assign ack        = ack_q;
  assign ready      = ready_q;
  assign rd_uninit  = rd_uninit_q;
  assign access_err = access_err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a behavioural model checked every cycle, plus directed
// sequences with literal expectations for reset, clear timing, RAW and saturation.
module tb_dmem_resp;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              cs;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] datin;
  logic [DATA_W-1:0] memdat;
  logic              ack;
  logic              ready;
  logic              rd_uninit;
  logic              access_err;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;

  int total = 0;
  int bad   = 0;

  dmem_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rw(rw), .address(address), .datin(datin),
    .memdat(memdat), .ack(ack), .ready(ready), .rd_uninit(rd_uninit),
    .access_err(access_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // behavioural model: counts edges since reset to know when the array is usable
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0]  m_written;
  int                m_edges;
  logic [DATA_W-1:0] m_memdat;
  logic              m_ack, m_uninit, m_err;
  int                m_rd, m_wr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_written <= '0;
      m_edges   <= 0;
      m_memdat  <= '0;
      m_ack     <= 1'b0;
      m_uninit  <= 1'b0;
      m_err     <= 1'b0;
      m_rd      <= 0;
      m_wr      <= 0;
    end else begin
      m_ack <= 1'b0;
      if (m_edges < DEPTH) begin
        m_edges <= m_edges + 1;
        if (cs) m_err <= 1'b1;
      end else if (cs && rw) begin
        m_memdat <= m_mem[address];
        m_ack    <= 1'b1;
        m_rd     <= (m_rd >= 255) ? 255 : m_rd + 1;
        if (!m_written[address]) m_uninit <= 1'b1;
      end else if (cs) begin
        m_mem[address]     <= datin;
        m_written[address] <= 1'b1;
        m_ack              <= 1'b1;
        m_wr               <= (m_wr >= 255) ? 255 : m_wr + 1;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    check("memdat", 32'(memdat), 32'(m_memdat));
    check("ack", 32'(ack), 32'(m_ack));
    check("ready", 32'(ready), (m_edges >= DEPTH) ? 32'd1 : 32'd0);
    check("rd_uninit", 32'(rd_uninit), 32'(m_uninit));
    check("access_err", 32'(access_err), 32'(m_err));
    check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
    check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input logic c, input logic r, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    cs = c; rw = r; address = a; datin = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b1, a, '0);
  endtask

  // asynchronous reset pulse, issued mid-cycle; outputs checked while low
  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_memdat"}, 32'(memdat), 32'h0);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_ready"}, 32'(ready), 32'h0);
    check({tag, "_flags"}, {30'h0, rd_uninit, access_err}, 32'h0);
    check({tag, "_cnts"}, {16'h0, rd_cnt, wr_cnt}, 32'h0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cs = 1'b0; rw = 1'b0; address = '0; datin = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_cnts", {16'h0, rd_cnt, wr_cnt}, 32'h0);
    rst = 1'b1;

    // clear timing: ready low for 15 edges, high on the 16th
    idle(15);
    check("ready_after15", 32'(ready), 32'h0);
    idle(1);
    check("ready_after16", 32'(ready), 32'h1);
    check("no_err_idle", 32'(access_err), 32'h0);
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i));
    idle(1);
    check("sweep_memdat", 32'(memdat), 32'h0);
    check("sweep_uninit", 32'(rd_uninit), 32'h1);
    check("sweep_rd_cnt", 32'(rd_cnt), 32'd16);

    // access during CLEAR is refused and flagged
    pulse_reset("rst_serve1");
    rd(4'd5);
    check("clr_no_ack", 32'(ack), 32'h0);
    check("clr_err", 32'(access_err), 32'h1);
    check("clr_cnts", {16'h0, rd_cnt, wr_cnt}, 32'h0);
    idle(15);
    check("clr_ready", 32'(ready), 32'h1);

    // read-after-write on consecutive edges
    wr(4'd3, 16'hBEEF);
    check("raw_wr_ack", 32'(ack), 32'h1);
    rd(4'd3);
    check("raw_rd_ack", 32'(ack), 32'h1);
    check("raw_memdat", 32'(memdat), 32'hBEEF);
    check("raw_cnts", {16'h0, rd_cnt, wr_cnt}, {16'h0, 8'd1, 8'd1});
    check("raw_uninit", 32'(rd_uninit), 32'h0);

    // controller-style back-to-back reads
    wr(4'd1, 16'h0005);
    wr(4'd2, 16'h0007);
    rd(4'd1);
    check("b2b_d1", 32'(memdat), 32'h0005);
    check("b2b_ack1", 32'(ack), 32'h1);
    rd(4'd2);
    check("b2b_d2", 32'(memdat), 32'h0007);
    check("b2b_ack2", 32'(ack), 32'h1);
    idle(1);
    check("b2b_ack_drop", 32'(ack), 32'h0);
    check("b2b_hold", 32'(memdat), 32'h0007);

    // read counter saturation
    for (int i = 0; i < 300; i++) rd(ADDR_W'(i % 3 + 1));
    check("sat_rd_cnt", 32'(rd_cnt), 32'd255);
    check("sat_wr_cnt", 32'(wr_cnt), 32'd3);
    rd(4'd2);
    check("sat_hold", 32'(rd_cnt), 32'd255);

    // reset mid-CLEAR at clr_ptr=7
    pulse_reset("rst_serve2");
    idle(7);
    pulse_reset("rst_clear");
    idle(16);
    check("reclear_ready", 32'(ready), 32'h1);

    // reset in SERVE after writing addr 0; the clear must erase it
    wr(4'd0, 16'h1234);
    rd(4'd0);
    check("pre_rst_data", 32'(memdat), 32'h1234);
    pulse_reset("rst_serve3");
    idle(16);
    rd(4'd0);
    check("post_rst_data", 32'(memdat), 32'h0);
    check("post_rst_uninit", 32'(rd_uninit), 32'h1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
